// File: rtl/riscv_pkg.sv
//============================================================================
// Module : riscv_pkg
// Brief  : Shared RISC-V core definitions: base opcodes, the canonical nop
//          word and the fetch-stage state encoding.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

package riscv_pkg;

  // Base-ISA major opcodes (instr[6:0])
  localparam logic [6:0] OP_R    = 7'd51;
  localparam logic [6:0] OP_LOAD = 7'd3;
  localparam logic [6:0] OP_I    = 7'd19;
  localparam logic [6:0] OP_S    = 7'd35;
  localparam logic [6:0] OP_U    = 7'd55;
  localparam logic [6:0] OP_B    = 7'd99;
  localparam logic [6:0] OP_JALR = 7'd103;
  localparam logic [6:0] OP_JAL  = 7'd111;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Fetch-stage sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

  // True when a byte address is word aligned
  function automatic logic is_word_aligned(input logic [1:0] addr_lsbs);
    return (addr_lsbs == 2'b00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/next_pc_sel.sv
//============================================================================
// Module : next_pc_sel
// Brief  : Combinational next-PC priority mux with branch-condition logic.
//          Priority: jalr target, jal, beq/bne, blt/bge, sequential.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module next_pc_sel #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm_ext,
  input  logic [XLEN-1:0] alu_result,
  input  logic            zero,
  input  logic            f3_lsb,
  input  logic            branch1,
  input  logic            branch2,
  input  logic            jmp,
  input  logic            sel1,
  output logic [XLEN-1:0] next_pc
);

  logic [XLEN-1:0] pc_rel;
  logic [XLEN-1:0] pc_seq;
  logic [XLEN-1:0] jalr_tgt;
  logic            eq_taken;
  logic            lt_taken;

  assign pc_rel   = pc + imm_ext;
  assign pc_seq   = pc + XLEN'(4);
  // jalr clears the target LSB
  assign jalr_tgt = alu_result & ~XLEN'(1);
  // f3[0] inverts the sense: beq/bne on zero, blt/bge on the slt result
  assign eq_taken = branch1 & (zero ^ f3_lsb);
  assign lt_taken = branch2 & (~zero ^ f3_lsb);

  // Priority select of the next program counter
  always_comb begin
    next_pc = pc_seq;
    if (sel1) begin
      next_pc = jalr_tgt;
    end else if (jmp) begin
      next_pc = pc_rel;
    end else if (eq_taken) begin
      next_pc = pc_rel;
    end else if (lt_taken) begin
      next_pc = pc_rel;
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
//============================================================================
// Module : instr_fetch_unit
// Brief  : Instruction fetch / PC sequencing stage. Owns the PC, fetches
//          words over a ready handshake with a bounded wait, holds the
//          current instruction and updates the PC once per EXEC cycle.
// Config : FETCH_MISALIGN_TRAP_EN - when defined, a misaligned next PC
//          raises fetch_err and halts instead of being word-aligned.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              MEM_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  input  logic            branch1,
  input  logic            branch2,
  input  logic            jmp,
  input  logic            sel1,
  input  logic            zero,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] imm_ext,
  output logic [31:0]     instr,
  output logic [6:0]      op,
  output logic [2:0]      f3,
  output logic [6:0]      f7,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            fetch_err
);

  localparam int              CNT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  fetch_state_t    state;
  fetch_state_t    state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [XLEN-1:0] pc_reg;
  logic [31:0]     instr_reg;
  logic            err_reg;
  logic [XLEN-1:0] next_pc_raw;
  logic [XLEN-1:0] pc_load_val;
  logic            instr_load;
  logic            pc_load;
  logic            err_set;
  logic            cnt_inc;
  logic            cnt_clr;

  next_pc_sel #(
    .XLEN (XLEN)
  ) u_next_pc_sel (
    .pc         (pc_reg),
    .imm_ext    (imm_ext),
    .alu_result (alu_result),
    .zero       (zero),
    .f3_lsb     (instr_reg[12]),
    .branch1    (branch1),
    .branch2    (branch2),
    .jmp        (jmp),
    .sel1       (sel1),
    .next_pc    (next_pc_raw)
  );

`ifdef FETCH_MISALIGN_TRAP_EN
  // Misaligned targets trap, so only aligned values are ever loaded
  assign pc_load_val = next_pc_raw;
`else
  // Misaligned targets are silently rounded down to a word boundary
  assign pc_load_val = next_pc_raw & ~XLEN'(3);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    instr_load  = 1'b0;
    pc_load     = 1'b0;
    err_set     = 1'b0;
    cnt_inc     = 1'b0;
    cnt_clr     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          instr_load = 1'b1;
          cnt_clr    = 1'b1;
          state_nxt  = ST_EXEC;
        end else if (wait_cnt == CNT_LAST) begin
          // MEM_TIMEOUT FETCH cycles have elapsed with no ready
          err_set   = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = ST_HALT;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_EXEC: begin
        instr_valid = 1'b1;
        cnt_clr     = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (!is_word_aligned(next_pc_raw[1:0])) begin
          err_set   = 1'b1;
          state_nxt = ST_HALT;
        end else begin
          pc_load   = 1'b1;
          state_nxt = ST_FETCH;
        end
`else
        pc_load   = 1'b1;
        state_nxt = ST_FETCH;
`endif
      end
      ST_HALT: begin
        state_nxt = ST_HALT;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // FETCH wait counter
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      wait_cnt <= '0;
    end else if (cnt_inc) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Program counter, updated only at the end of EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg <= RESET_PC;
    end else if (pc_load) begin
      pc_reg <= pc_load_val;
    end
  end

  // Instruction register, captured on the FETCH handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_reg <= NOP_INSTR;
    end else if (instr_load) begin
      instr_reg <= imem_rdata;
    end
  end

  // Sticky timeout / trap flag
  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (err_set) begin
      err_reg <= 1'b1;
    end
  end

  assign imem_addr = pc_reg;
  assign pc        = pc_reg;
  assign pc_plus4  = pc_reg + XLEN'(4);
  assign instr     = instr_reg;
  assign op        = instr_reg[6:0];
  assign f3        = instr_reg[14:12];
  assign f7        = instr_reg[31:25];
  assign fetch_err = err_reg;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
//============================================================================
// Module : tb_instr_fetch_unit
// Brief  : Directed self-checking bench for instr_fetch_unit.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module tb_instr_fetch_unit;

  localparam logic [31:0] W_ADDI = 32'h0010_8093;  // addi x1, x1, 1
  localparam logic [31:0] W_BEQ  = 32'h0000_0063;  // f3 = 000
  localparam logic [31:0] W_BLT  = 32'h0000_4063;  // f3 = 100
  localparam logic [31:0] W_BGE  = 32'h0000_5063;  // f3 = 101
  localparam logic [31:0] W_JALR = 32'h0000_8067;
  localparam logic [31:0] W_JAL  = 32'h0000_006f;
  localparam logic [31:0] W_R    = 32'h4020_80b3;  // sub: f7 = 0100000

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        branch1 = 1'b0;
  logic        branch2 = 1'b0;
  logic        jmp = 1'b0;
  logic        sel1 = 1'b0;
  logic        zero = 1'b0;
  logic [31:0] alu_result = '0;
  logic [31:0] imm_ext = '0;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_err;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_pc = '0;
  logic [31:0] jalr_alu;

  instr_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .branch1     (branch1),
    .branch2     (branch2),
    .jmp         (jmp),
    .sel1        (sel1),
    .zero        (zero),
    .alu_result  (alu_result),
    .imm_ext     (imm_ext),
    .instr       (instr),
    .op          (op),
    .f3          (f3),
    .f7          (f7),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  // Compare one observed value with its expected value
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    model_pc = 32'h0;
  endtask

  // Run one instruction starting in FETCH; controls are applied only in EXEC
  task automatic do_instr(input logic [31:0] word, input int waits,
                          input logic b1, input logic b2, input logic j,
                          input logic s1, input logic z,
                          input logic [31:0] alu, input logic [31:0] imm,
                          input logic [31:0] exp_pc);
    check("fetch_req", imem_req, 1);
    check("fetch_addr", imem_addr, model_pc);
    for (int w = 0; w < waits; w++) begin
      step();
      check("wait_req", imem_req, 1);
      check("wait_addr", imem_addr, model_pc);
    end
    imem_ready = 1'b1;
    imem_rdata = word;
    step();
    imem_ready = 1'b0;
    imem_rdata = 32'hdead_beef;
    check("exec_valid", instr_valid, 1);
    check("exec_req", imem_req, 0);
    check("instr", instr, word);
    check("op", op, word[6:0]);
    check("f3", f3, word[14:12]);
    check("f7", f7, word[31:25]);
    check("exec_pc", pc, model_pc);
    check("pc_plus4", pc_plus4, model_pc + 32'd4);
    branch1 = b1; branch2 = b2; jmp = j; sel1 = s1; zero = z;
    alu_result = alu; imm_ext = imm;
    step();
    branch1 = 1'b0; branch2 = 1'b0; jmp = 1'b0; sel1 = 1'b0; zero = 1'b0;
    alu_result = '0; imm_ext = '0;
    check("valid_low", instr_valid, 0);
    check("next_pc", pc, exp_pc);
    model_pc = exp_pc;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_req", imem_req, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_err", fetch_err, 0);
    step();  // IDLE -> FETCH

    // Sequential addi stream; controls driven during FETCH must not matter
    jmp = 1'b1; imm_ext = 32'h100;
    do_instr(W_ADDI, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'd4);
    do_instr(W_ADDI, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'd8);
    // beq taken from pc=8
    do_instr(W_BEQ, 0, 1, 0, 0, 0, 1, 32'h0, 32'd16, 32'd24);

    // Reset in FETCH abandons the fetch
    rst = 1'b1;
    step();
    check("rstf_req", imem_req, 0);
    check("rstf_pc", pc, 32'h0);
    rst = 1'b0;
    step();
    model_pc = 32'h0;

    do_instr(W_ADDI, 2, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'd4);    // 2 wait states
    do_instr(W_R, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'd8);
    do_instr(W_BEQ, 0, 1, 0, 0, 0, 0, 32'h0, 32'd16, 32'd12);   // beq not taken
    do_instr(W_BLT, 0, 0, 1, 0, 0, 1, 32'h0, 32'd16, 32'd16);   // blt not taken
    do_instr(W_BGE, 0, 0, 1, 0, 0, 1, 32'h0, 32'd16, 32'd32);   // bge taken
`ifdef FETCH_MISALIGN_TRAP_EN
    jalr_alu = 32'h0000_0101;
`else
    jalr_alu = 32'h0000_0103;
`endif
    // jalr beats jmp
    do_instr(W_JALR, 0, 0, 0, 1, 1, 0, jalr_alu, 32'd64, 32'h100);
    // jmp beats a taken branch
    do_instr(W_JAL, 0, 1, 0, 1, 0, 1, 32'h0, 32'd8, 32'h108);

    // Misaligned jal from pc=0
    do_reset();
    step();
`ifdef FETCH_MISALIGN_TRAP_EN
    imem_ready = 1'b1;
    imem_rdata = W_JAL;
    step();
    imem_ready = 1'b0;
    jmp = 1'b1; imm_ext = 32'd6;
    step();
    jmp = 1'b0; imm_ext = '0;
    check("mis_err", fetch_err, 1);
    check("mis_req", imem_req, 0);
    check("mis_pc", pc, 32'h0);
`else
    do_instr(W_JAL, 0, 0, 0, 1, 0, 0, 32'h0, 32'd6, 32'd4);
`endif

    // Fetch timeout
    do_reset();
    step();
    for (int i = 0; i < 16; i++) begin
      check("to_req", imem_req, 1);
      check("to_addr", imem_addr, 32'h0);
      step();
    end
    check("to_err", fetch_err, 1);
    check("to_req_low", imem_req, 0);
    imem_ready = 1'b1;
    imem_rdata = W_ADDI;
    step();
    step();
    imem_ready = 1'b0;
    check("halt_req", imem_req, 0);
    check("halt_valid", instr_valid, 0);
    check("halt_err", fetch_err, 1);
    check("halt_instr", instr, 32'h0000_0013);
    do_reset();
    check("rec_pc", pc, 32'h0);
    check("rec_err", fetch_err, 0);
    step();
    check("rec_req", imem_req, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
